param_datapath: RTL and testbench
=================================

PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data/address width (legal range >= 16).
REQ-002 SHALL have parameter PC_INIT, default 0, PC value after reset.
REQ-003 SHALL have parameter TIMEOUT, default 255, max wait cycles for Mem_Rdy.
REQ-004 SHALL have ports:
- Clk  in  1  single clock; all state on its rising edge.
- Reset  in  1  synchronous, active-high.
- Ld  in  7  load enables {PC,IR,MAR,MDR,REG,CC,BEN}, bit 6 = PC.
- Gate  in  4  bus drivers {PC,MDR,ALU,MARMUX}, bit 3 = PC.
- PCMUX  in  2  PC source select.
- ADDR1MUX  in  1  address base: 0=PC, 1=SR1.
- ADDR2MUX  in  2  offset: 0=zero, 1=sext IR[5:0], 2=sext IR[8:0], 3=sext IR[10:0].
- DRMUX  in  1  dest: 0=IR[11:9], 1=R7.
- SR1MUX  in  1  SR1: 0=IR[11:9], 1=IR[8:6].
- SR2MUX  in  1  ALU B: 0=R[IR[2:0]], 1=sext IR[4:0].
- ALUK  in  2  ALU op.
- MIO_EN  in  1  MDR load source: 1=memory read, 0=Bus.
- MEM_WE  in  1  start memory write of MDR to MAR.
- Mem_Rdy  in  1  memory completion strobe.
- Mem_Rdata  in  WIDTH  memory read data.
- PC, IR, MAR, MDR  out  WIDTH each  register contents; MAR is memory address.
- Mem_Wdata  out  WIDTH  equals MDR.
- Mem_Rd, Mem_Wr  out  1 each  high throughout READ/WRITE state.
- Busy  out  1  memory FSM not IDLE.
- Mem_Err  out  1  sticky timeout flag.
- BEN  out  1  branch enable register.
- Bus_Err  out  1  combinational: more than one Gate bit high.
- Bus  out  WIDTH  internal bus value.

Function
REQ-005 Bus SHALL equal the single gated source; zero Gate bits or Bus_Err -> Bus = 0.
REQ-006 MARMUX value SHALL be ADDR1 + ADDR2 offset, modulo 2^WIDTH.
REQ-007 Ld[PC] SHALL load PCMUX: 0=PC+1 (wraps all-ones -> 0), 1=Bus, 2=MARMUX, 3=hold.
REQ-008 Ld[IR] SHALL load Bus; Ld[REG] SHALL write Bus to DR; R0..R7 are WIDTH bits.
REQ-009 ALUK SHALL select 0=A+B (mod 2^WIDTH), 1=A&B, 2=~A, 3=A; A=R[SR1].
REQ-010 Ld[CC] SHALL set exactly one of N(Bus msb)/Z(Bus==0)/P(otherwise); Ld[BEN] SHALL load |(IR[11:9] & {N,Z,P}).
REQ-011 Memory FSM states IDLE, READ, WRITE; IDLE + Ld[MDR] + MIO_EN -> READ; IDLE + MEM_WE -> WRITE.
REQ-012 Both requests in the same IDLE cycle: READ wins, MEM_WE dropped.
REQ-013 READ/WRITE + Mem_Rdy -> IDLE; READ also loads MDR<=Mem_Rdata on that edge; minimum transaction = 2 cycles.
REQ-014 Wait counter SHALL clear on entry; after TIMEOUT cycles without Mem_Rdy -> IDLE, Mem_Err<=1, MDR unchanged.
REQ-015 Ld[MDR] with MIO_EN=0 SHALL load Bus in 1 cycle, ignored while Busy.
REQ-016 Ld[MAR] and new memory requests SHALL be ignored while Busy.
REQ-017 Simultaneous Ld targets SHALL all sample the same pre-edge Bus.

Reset
REQ-018 Reset SHALL set PC=PC_INIT; IR, MAR, MDR, R0..R7 = 0; NZP=010; BEN=0; Mem_Err=0; FSM=IDLE; counter=0.
REQ-019 Reset mid-transaction SHALL abort it; Mem_Rd/Mem_Wr low the cycle after the reset edge.

Structure
REQ-020 Package dp_pkg SHALL hold ALUK, PCMUX, ADDR2MUX and memory-state enums.
REQ-021 Register file SHALL be sub-module dp_regfile (8 x WIDTH, one write port, two combinational read ports).

Verification
REQ-022 Reset, Ld[PC] PCMUX=0 x3 -> PC = 0,1,2,3; PC=FFFF + PC+1 -> 0000.
REQ-023 Gate=1000 and 0100 together -> Bus_Err=1, Bus=0; no Ld target corrupted beyond loading 0.
REQ-024 MAR=0x3000, Ld[MDR]+MIO_EN, Mem_Rdy on 3rd cycle with 0xBEEF -> Mem_Rd high 3 cycles, MDR=0xBEEF, Busy low next cycle.
REQ-025 Read with Mem_Rdy never asserted, TIMEOUT=4 -> IDLE after 4 wait cycles, Mem_Err=1 until Reset.
REQ-026 R1=5, IR=ADD R2,R1,#-3, GateALU, Ld[REG]+Ld[CC] -> R2=2, NZP=001; IR[11:9]=001 + Ld[BEN] -> BEN=1.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared encodings for the parameterised datapath: mux selects, ALU ops,
// memory FSM states and the bit positions inside the Ld and Gate vectors.
package dp_pkg;

  typedef enum logic [1:0] {ALUK_ADD, ALUK_AND, ALUK_NOT, ALUK_PASS} aluk_e;
  typedef enum logic [1:0] {PCMUX_INC, PCMUX_BUS, PCMUX_MARMUX, PCMUX_HOLD} pcmux_e;
  typedef enum logic [1:0] {ADDR2_ZERO, ADDR2_OFF6, ADDR2_OFF9, ADDR2_OFF11} addr2mux_e;
  typedef enum logic [1:0] {MEM_IDLE, MEM_READ, MEM_WRITE} mem_state_e;

  localparam int LD_PC  = 6;
  localparam int LD_IR  = 5;
  localparam int LD_MAR = 4;
  localparam int LD_MDR = 3;
  localparam int LD_REG = 2;
  localparam int LD_CC  = 1;
  localparam int LD_BEN = 0;

  localparam int GATE_PC     = 3;
  localparam int GATE_MDR    = 2;
  localparam int GATE_ALU    = 1;
  localparam int GATE_MARMUX = 0;

  // True when more than one bus driver is enabled.
  function automatic logic multi_hot4(input logic [3:0] g);
    return (g & (g - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/dp_regfile.sv
// Eight-entry general purpose register file: one synchronous write port,
// two combinational read ports.
module dp_regfile #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             we,
  input  logic [2:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [2:0]       raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [2:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] regs [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_reg
      logic [WIDTH-1:0] r_reg;
      always_ff @(posedge clk) begin
        if (srst) begin
          r_reg <= '0;
        end else if (we && (waddr == 3'(gi))) begin
          r_reg <= wdata;
        end
      end
      assign regs[gi] = r_reg;
    end
  endgenerate

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/param_datapath.sv
// Bus-based datapath: PC/IR/MAR/MDR, register file, ALU, address adder,
// condition codes and a handshaked memory FSM with a timeout watchdog.
module param_datapath
  import dp_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] PC_INIT = '0,
  parameter int               TIMEOUT = 255
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [6:0]       Ld,
  input  logic [3:0]       Gate,
  input  logic [1:0]       PCMUX,
  input  logic             ADDR1MUX,
  input  logic [1:0]       ADDR2MUX,
  input  logic             DRMUX,
  input  logic             SR1MUX,
  input  logic             SR2MUX,
  input  logic [1:0]       ALUK,
  input  logic             MIO_EN,
  input  logic             MEM_WE,
  input  logic             Mem_Rdy,
  input  logic [WIDTH-1:0] Mem_Rdata,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] MAR,
  output logic [WIDTH-1:0] MDR,
  output logic [WIDTH-1:0] Mem_Wdata,
  output logic             Mem_Rd,
  output logic             Mem_Wr,
  output logic             Busy,
  output logic             Mem_Err,
  output logic             BEN,
  output logic             Bus_Err,
  output logic [WIDTH-1:0] Bus
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [WIDTH-1:0] pc_reg, ir_reg, mar_reg, mdr_reg;
  logic             n_reg, z_reg, p_reg, ben_reg, mem_err_reg;
  mem_state_e       state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic             timeout_hit;

  logic [WIDTH-1:0] bus, alu_out, marmux_out, addr1, addr2, alu_b;
  logic [WIDTH-1:0] sr1_val, sr2_val;
  logic [2:0]       dr_sel, sr1_sel;
  logic             busy, read_done;

  assign dr_sel  = DRMUX  ? 3'd7 : ir_reg[11:9];
  assign sr1_sel = SR1MUX ? ir_reg[8:6] : ir_reg[11:9];

  dp_regfile #(.WIDTH(WIDTH)) u_regfile (
    .clk     (Clk),
    .srst    (Reset),
    .we      (Ld[LD_REG]),
    .waddr   (dr_sel),
    .wdata   (bus),
    .raddr_a (sr1_sel),
    .rdata_a (sr1_val),
    .raddr_b (ir_reg[2:0]),
    .rdata_b (sr2_val)
  );

  always_comb begin
    alu_b = SR2MUX ? {{(WIDTH-5){ir_reg[4]}}, ir_reg[4:0]} : sr2_val;
    case (aluk_e'(ALUK))
      ALUK_ADD: alu_out = sr1_val + alu_b;
      ALUK_AND: alu_out = sr1_val & alu_b;
      ALUK_NOT: alu_out = ~sr1_val;
      default:  alu_out = sr1_val;
    endcase
  end

  always_comb begin
    addr1 = ADDR1MUX ? sr1_val : pc_reg;
    case (addr2mux_e'(ADDR2MUX))
      ADDR2_OFF6:  addr2 = {{(WIDTH-6){ir_reg[5]}},   ir_reg[5:0]};
      ADDR2_OFF9:  addr2 = {{(WIDTH-9){ir_reg[8]}},   ir_reg[8:0]};
      ADDR2_OFF11: addr2 = {{(WIDTH-11){ir_reg[10]}}, ir_reg[10:0]};
      default:     addr2 = '0;
    endcase
    marmux_out = addr1 + addr2;
  end

  // Any gate pattern that is not exactly one-hot leaves the bus at zero.
  always_comb begin
    case (Gate)
      4'b1000: bus = pc_reg;
      4'b0100: bus = mdr_reg;
      4'b0010: bus = alu_out;
      4'b0001: bus = marmux_out;
      default: bus = '0;
    endcase
  end

  // Memory FSM: state register, next-state logic, outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= MEM_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= (state_reg == MEM_IDLE || state_next == MEM_IDLE) ? '0 : cnt_reg + CW'(1);
    end
  end

  always_comb begin
    state_next  = state_reg;
    timeout_hit = 1'b0;
    case (state_reg)
      MEM_IDLE: begin
        if (Ld[LD_MDR] && MIO_EN) state_next = MEM_READ;
        else if (MEM_WE)          state_next = MEM_WRITE;
      end
      MEM_READ, MEM_WRITE: begin
        if (Mem_Rdy) begin
          state_next = MEM_IDLE;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          state_next  = MEM_IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: state_next = MEM_IDLE;
    endcase
  end

  always_comb begin
    Mem_Rd    = (state_reg == MEM_READ);
    Mem_Wr    = (state_reg == MEM_WRITE);
    busy      = (state_reg != MEM_IDLE);
    read_done = (state_reg == MEM_READ) && Mem_Rdy;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_reg      <= PC_INIT;
      ir_reg      <= '0;
      mar_reg     <= '0;
      mdr_reg     <= '0;
      n_reg       <= 1'b0;
      z_reg       <= 1'b1;
      p_reg       <= 1'b0;
      ben_reg     <= 1'b0;
      mem_err_reg <= 1'b0;
    end else begin
      if (Ld[LD_PC]) begin
        case (pcmux_e'(PCMUX))
          PCMUX_INC:    pc_reg <= pc_reg + WIDTH'(1);
          PCMUX_BUS:    pc_reg <= bus;
          PCMUX_MARMUX: pc_reg <= marmux_out;
          default:      pc_reg <= pc_reg;
        endcase
      end
      if (Ld[LD_IR]) ir_reg <= bus;
      if (Ld[LD_MAR] && !busy) mar_reg <= bus;
      if (read_done) begin
        mdr_reg <= Mem_Rdata;
      end else if (Ld[LD_MDR] && !MIO_EN && !busy) begin
        mdr_reg <= bus;
      end
      if (Ld[LD_CC]) begin
        n_reg <= bus[WIDTH-1];
        z_reg <= (bus == '0);
        p_reg <= !bus[WIDTH-1] && (bus != '0);
      end
      if (Ld[LD_BEN]) ben_reg <= |(ir_reg[11:9] & {n_reg, z_reg, p_reg});
      if (timeout_hit) mem_err_reg <= 1'b1;
    end
  end

  assign PC        = pc_reg;
  assign IR        = ir_reg;
  assign MAR       = mar_reg;
  assign MDR       = mdr_reg;
  assign Mem_Wdata = mdr_reg;
  assign Busy      = busy;
  assign Mem_Err   = mem_err_reg;
  assign BEN       = ben_reg;
  assign Bus_Err   = multi_hot4(Gate);
  assign Bus       = bus;

endmodule

// File: tb/tb_param_datapath.sv
// Directed stimulus with a scoreboard queue; a negedge monitor pops each
// expected observation and compares it against the selected DUT output.
module tb_param_datapath;

    localparam int S_PC = 0, S_IR = 1, S_MAR = 2, S_MDR = 3, S_BUS = 4, S_BUSERR = 5;
    localparam int S_RD = 6, S_WR = 7, S_BUSY = 8, S_ERR = 9, S_BEN = 10, S_WDATA = 11;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        Reset;
    logic [6:0]  Ld;
    logic [3:0]  Gate;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        ADDR1MUX, DRMUX, SR1MUX, SR2MUX, MIO_EN, MEM_WE, Mem_Rdy;
    logic [15:0] Mem_Rdata;
    logic [15:0] PC, IR, MAR, MDR, Mem_Wdata, Bus;
    logic        Mem_Rd, Mem_Wr, Busy, Mem_Err, BEN, Bus_Err;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    param_datapath #(.WIDTH(16), .PC_INIT(16'h0000), .TIMEOUT(4)) dut (
        .Clk(clk), .Reset(Reset), .Ld(Ld), .Gate(Gate), .PCMUX(PCMUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX),
        .SR2MUX(SR2MUX), .ALUK(ALUK), .MIO_EN(MIO_EN), .MEM_WE(MEM_WE),
        .Mem_Rdy(Mem_Rdy), .Mem_Rdata(Mem_Rdata), .PC(PC), .IR(IR), .MAR(MAR),
        .MDR(MDR), .Mem_Wdata(Mem_Wdata), .Mem_Rd(Mem_Rd), .Mem_Wr(Mem_Wr),
        .Busy(Busy), .Mem_Err(Mem_Err), .BEN(BEN), .Bus_Err(Bus_Err), .Bus(Bus)
    );

    function automatic logic [15:0] obs(input int sel);
        case (sel)
            S_PC:     return PC;
            S_IR:     return IR;
            S_MAR:    return MAR;
            S_MDR:    return MDR;
            S_BUS:    return Bus;
            S_BUSERR: return {15'd0, Bus_Err};
            S_RD:     return {15'd0, Mem_Rd};
            S_WR:     return {15'd0, Mem_Wr};
            S_BUSY:   return {15'd0, Busy};
            S_ERR:    return {15'd0, Mem_Err};
            S_BEN:    return {15'd0, BEN};
            default:  return Mem_Wdata;
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [15:0] got;
            e   = q.pop_front();
            got = obs(e.sel);
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.name, got, e.val);
            end else begin
                $display("ok   %s = %h", e.name, got);
            end
        end
    end

    task automatic expect_val(input string nm, input int sel, input logic [15:0] v);
        exp_t e;
        e.name = nm; e.sel = sel; e.val = v;
        q.push_back(e);
    endtask

    task automatic check_now(input string nm, input logic [15:0] got, input logic [15:0] v);
        n_checks++;
        if (got !== v) begin
            n_fail++;
            $display("FAIL %s (direct): got %h expected %h", nm, got, v);
        end else begin
            $display("ok   %s (direct) = %h", nm, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Ld = 7'd0; Gate = 4'd0; PCMUX = 2'd0; ADDR1MUX = 1'b0; ADDR2MUX = 2'd0;
        DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0; ALUK = 2'd0;
        MIO_EN = 1'b0; MEM_WE = 1'b0; Mem_Rdy = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] data);
        idle_inputs();
        Ld = 7'b0001000; MIO_EN = 1'b1;
        tick();
        idle_inputs();
        Mem_Rdy = 1'b1; Mem_Rdata = data;
        tick();
        Mem_Rdy = 1'b0;
        expect_val("mdr_after_read", S_MDR, data);
    endtask

    task automatic load_from_mdr(input logic [6:0] ld);
        idle_inputs();
        Gate = 4'b0100; Ld = ld;
        tick();
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        Mem_Rdata = 16'h0000;
        Reset = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        check_now("rst_pc_now", PC, 16'h0000);
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy_now: got %b expected 0", Busy);
        end else begin
            $display("ok   rst_busy_now = %b", Busy);
        end
        n_checks++;
        expect_val("rst_pc", S_PC, 16'h0000);
        expect_val("rst_ir", S_IR, 16'h0000);
        expect_val("rst_mar", S_MAR, 16'h0000);
        expect_val("rst_mdr", S_MDR, 16'h0000);
        expect_val("rst_busy", S_BUSY, 16'h0000);
        expect_val("rst_err", S_ERR, 16'h0000);
        expect_val("rst_ben", S_BEN, 16'h0000);
        expect_val("rst_bus_idle", S_BUS, 16'h0000);

        Ld = 7'b1000000; PCMUX = 2'd0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            expect_val("pc_inc", S_PC, 16'(i));
        end
        idle_inputs();
        Gate = 4'b0010; ALUK = 2'd2; SR1MUX = 1'b0; Ld = 7'b1000000; PCMUX = 2'd1;
        expect_val("bus_not_r0", S_BUS, 16'hFFFF);
        tick();
        expect_val("pc_from_bus", S_PC, 16'hFFFF);
        idle_inputs();
        Ld = 7'b1000000; PCMUX = 2'd0;
        tick();
        check_now("pc_wrap_now", PC, 16'h0000);
        expect_val("pc_wrap", S_PC, 16'h0000);
        idle_inputs();

        do_read(16'h3000);
        load_from_mdr(7'b0010000);
        expect_val("mar_load", S_MAR, 16'h3000);
        Ld = 7'b0001000; MIO_EN = 1'b1;
        tick();
        idle_inputs();
        Gate = 4'b1000; Ld = 7'b0011000;
        expect_val("rd_c1", S_RD, 16'h0001);
        expect_val("busy_c1", S_BUSY, 16'h0001);
        tick();
        idle_inputs();
        expect_val("mar_ignored_busy", S_MAR, 16'h3000);
        expect_val("mdr_ignored_busy", S_MDR, 16'h3000);
        expect_val("rd_c2", S_RD, 16'h0001);
        tick();
        expect_val("rd_c3", S_RD, 16'h0001);
        Mem_Rdy = 1'b1; Mem_Rdata = 16'hBEEF;
        tick();
        Mem_Rdy = 1'b0;
        check_now("mdr_beef_now", MDR, 16'hBEEF);
        expect_val("rd_done", S_RD, 16'h0000);
        expect_val("busy_done", S_BUSY, 16'h0000);
        expect_val("mdr_beef", S_MDR, 16'hBEEF);
        expect_val("wdata_beef", S_WDATA, 16'hBEEF);

        Gate = 4'b0100; Ld = 7'b1110000; PCMUX = 2'd1;
        tick();
        idle_inputs();
        expect_val("multi_pc", S_PC, 16'hBEEF);
        expect_val("multi_ir", S_IR, 16'hBEEF);
        expect_val("multi_mar", S_MAR, 16'hBEEF);

        MEM_WE = 1'b1;
        tick();
        idle_inputs();
        expect_val("wr_active", S_WR, 16'h0001);
        expect_val("wr_not_rd", S_RD, 16'h0000);
        expect_val("wr_wdata", S_WDATA, 16'hBEEF);
        Mem_Rdy = 1'b1;
        tick();
        Mem_Rdy = 1'b0;
        expect_val("wr_done", S_WR, 16'h0000);
        expect_val("wr_busy_done", S_BUSY, 16'h0000);

        Gate = 4'b1100; Ld = 7'b1101000; PCMUX = 2'd1;
        #1;
        check_now("conflict_err_now", {15'd0, Bus_Err}, 16'h0001);
        check_now("conflict_bus_now", Bus, 16'h0000);
        expect_val("conflict_err", S_BUSERR, 16'h0001);
        expect_val("conflict_bus", S_BUS, 16'h0000);
        tick();
        idle_inputs();
        expect_val("conflict_err_clear", S_BUSERR, 16'h0000);
        expect_val("conflict_pc", S_PC, 16'h0000);
        expect_val("conflict_ir", S_IR, 16'h0000);
        expect_val("conflict_mdr", S_MDR, 16'h0000);
        expect_val("conflict_mar_kept", S_MAR, 16'hBEEF);

        Ld = 7'b0001000; MIO_EN = 1'b1; MEM_WE = 1'b1;
        tick();
        idle_inputs();
        expect_val("both_rd", S_RD, 16'h0001);
        expect_val("both_wr", S_WR, 16'h0000);
        Mem_Rdy = 1'b1; Mem_Rdata = 16'h1234;
        tick();
        Mem_Rdy = 1'b0;
        expect_val("both_mdr", S_MDR, 16'h1234);
        expect_val("both_idle", S_BUSY, 16'h0000);

        do_read(16'h0200);
        load_from_mdr(7'b0100000);
        do_read(16'h0005);
        load_from_mdr(7'b0000100);
        do_read(16'h147D);
        load_from_mdr(7'b0100000);
        expect_val("ir_add", S_IR, 16'h147D);
        Gate = 4'b0010; ALUK = 2'd0; SR1MUX = 1'b1; SR2MUX = 1'b1; Ld = 7'b0000110;
        expect_val("alu_add_imm", S_BUS, 16'h0002);
        tick();
        idle_inputs();
        Ld = 7'b0000001;
        tick();
        idle_inputs();
        expect_val("ben_010_vs_p", S_BEN, 16'h0000);
        Gate = 4'b0010; ALUK = 2'd3; SR1MUX = 1'b0;
        expect_val("r2_readback", S_BUS, 16'h0002);
        tick();
        Gate = 4'b0010; ALUK = 2'd1; SR1MUX = 1'b1; SR2MUX = 1'b1;
        expect_val("alu_and", S_BUS, 16'h0005);
        tick();
        Gate = 4'b0010; ALUK = 2'd2; SR1MUX = 1'b1;
        expect_val("alu_not", S_BUS, 16'hFFFA);
        tick();
        idle_inputs();
        Gate = 4'b0001; ADDR1MUX = 1'b1; SR1MUX = 1'b1; ADDR2MUX = 2'd1;
        expect_val("marmux_off6", S_BUS, 16'h0002);
        tick();
        ADDR2MUX = 2'd2;
        expect_val("marmux_off9", S_BUS, 16'h0082);
        tick();
        ADDR2MUX = 2'd3; Ld = 7'b1000000; PCMUX = 2'd2;
        expect_val("marmux_off11", S_BUS, 16'hFC82);
        tick();
        idle_inputs();
        expect_val("pc_marmux", S_PC, 16'hFC82);

        do_read(16'h0200);
        load_from_mdr(7'b0100000);
        Ld = 7'b0000001;
        tick();
        idle_inputs();
        expect_val("ben_p", S_BEN, 16'h0001);
        Gate = 4'b0010; ALUK = 2'd2; SR1MUX = 1'b1; Ld = 7'b0000010;
        tick();
        idle_inputs();
        Ld = 7'b0000001;
        tick();
        idle_inputs();
        expect_val("ben_n", S_BEN, 16'h0000);

        Ld = 7'b0001000; MIO_EN = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            expect_val("to_rd_wait", S_RD, 16'h0001);
            tick();
        end
        check_now("to_err_now", {15'd0, Mem_Err}, 16'h0001);
        expect_val("to_idle", S_BUSY, 16'h0000);
        expect_val("to_err", S_ERR, 16'h0001);
        expect_val("to_mdr_kept", S_MDR, 16'h0200);
        tick();
        expect_val("to_err_sticky", S_ERR, 16'h0001);

        Ld = 7'b0001000; MIO_EN = 1'b1;
        tick();
        idle_inputs();
        expect_val("mid_rd", S_RD, 16'h0001);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_now("mid_rst_rd_now", {15'd0, Mem_Rd}, 16'h0000);
        expect_val("mid_rst_rd", S_RD, 16'h0000);
        expect_val("mid_rst_busy", S_BUSY, 16'h0000);
        expect_val("mid_rst_err", S_ERR, 16'h0000);
        expect_val("mid_rst_pc", S_PC, 16'h0000);
        expect_val("mid_rst_mdr", S_MDR, 16'h0000);
        tick();
        expect_val("post_rst_busy", S_BUSY, 16'h0000);
        tick();
        tick();
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard: %0d expectations not consumed", q.size());
        end
        if (n_checks < 12) begin
            n_fail++;
            $display("FAIL coverage: only %0d checks evaluated", n_checks);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        if (n_fail == 0) begin
            $display("PASS");
        end else begin
            $display("FAIL");
        end
        $finish;
    end

endmodule
